mem_bus_arbiter: RTL and testbench

Shares one SRAM-style memory bus between the instruction-fetch port and the MEM-stage data port. MEM-stage requests, including byte/half/word loads and stores with byte-lane selects, take priority over fetch. Each bus cycle runs to acknowledge or timeout under a small FSM. The block stalls the pipeline until every active requester has been served, and holds each requester's read result stable until the pipeline advances.

---
 rtl/mem_bus_arbiter_pkg.sv | 31 +++
 rtl/mem_bus_arbiter_if.sv | 51 +++++
 rtl/bus_timeout_cnt.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_pkg
//  Description : Shared types and constants for the memory bus arbiter:
//                FSM state encoding, request-owner codes, bus widths and a
//                helper that maps a bus state to the port that owns it.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

   localparam int c_reg_bus_w = 32;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_BUS_DATA = 2'd1,
      ARB_BUS_INST = 2'd2
   } arb_state_t;

   // Owner of the current bus cycle
   localparam logic c_req_inst = 1'b0;
   localparam logic c_req_data = 1'b1;

   // Fetches always read the whole word
   localparam logic [3:0] c_sel_all = 4'b1111;

   function automatic logic owner_of(input arb_state_t s);
      return (s == ARB_BUS_DATA) ? c_req_data : c_req_inst;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_if
//  Description : Pipeline-side request ports and memory-bus signals of the
//                arbiter, bundled for connection as one port.
//                master : arbiter view (drives results, stalls, bus outputs)
//                slave  : environment view (pipeline + memory slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if;
   import mem_bus_arbiter_pkg::*;

   // pipeline side
   logic                   flush_i;
   logic                   inst_ce_i;
   logic [c_reg_bus_w-1:0] inst_addr_i;
   logic [c_reg_bus_w-1:0] inst_rdata_o;
   logic                   data_ce_i;
   logic                   data_we_i;
   logic [3:0]             data_sel_i;
   logic [c_reg_bus_w-1:0] data_addr_i;
   logic [c_reg_bus_w-1:0] data_wdata_i;
   logic [c_reg_bus_w-1:0] data_rdata_o;
   logic                   stallreq_if_o;
   logic                   stallreq_mem_o;
   // memory bus side
   logic                   bus_req_o;
   logic                   bus_we_o;
   logic [3:0]             bus_sel_o;
   logic [c_reg_bus_w-1:0] bus_addr_o;
   logic [c_reg_bus_w-1:0] bus_wdata_o;
   logic [c_reg_bus_w-1:0] bus_rdata_i;
   logic                   bus_ack_i;
   logic                   bus_err_o;

   modport master (
      input  flush_i, inst_ce_i, inst_addr_i, data_ce_i, data_we_i,
             data_sel_i, data_addr_i, data_wdata_i, bus_rdata_i, bus_ack_i,
      output inst_rdata_o, data_rdata_o, stallreq_if_o, stallreq_mem_o,
             bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o
   );

   modport slave (
      output flush_i, inst_ce_i, inst_addr_i, data_ce_i, data_we_i,
             data_sel_i, data_addr_i, data_wdata_i, bus_rdata_i, bus_ack_i,
      input  inst_rdata_o, data_rdata_o, stallreq_if_o, stallreq_mem_o,
             bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o
   );

endinterface
`default_nettype wire

// File: rtl/bus_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timeout_cnt
//  Description : Wait-state counter for one bus cycle. Cleared on i_start,
//                counts every cycle i_en is high, and flags o_expired while
//                enabled with the count at TIMEOUT-1.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_start        - clear (first bus cycle begins next)
//                i_en           - bus cycle in progress
//                o_expired      - last allowed cycle reached
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_cnt #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_en,
   output logic o_expired
);

   localparam int              c_cnt_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

   logic [c_cnt_w-1:0] r_cnt;

   // A wrap after expiry is harmless: the next bus cycle starts with a clear.
   always_ff @(posedge clk) begin
      if (rst || i_start) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = i_en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares one SRAM-style bus between instruction fetch and the
//                MEM-stage data port (data has priority). Each bus cycle runs
//                to ack or timeout; the pipeline is stalled until every active
//                requester is served and read results are held until advance.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                bif       - mem_bus_arbiter_if.master (pipeline + bus)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   mem_bus_arbiter_if.master  bif
);

   arb_state_t             r_state;
   arb_state_t             w_state_nxt;
   logic                   r_served_d;
   logic                   r_served_i;
   logic                   r_flushed;     // flush seen during the current bus cycle
   logic                   r_bus_req;
   logic                   r_bus_we;
   logic [3:0]             r_bus_sel;
   logic [c_reg_bus_w-1:0] r_bus_addr;
   logic [c_reg_bus_w-1:0] r_bus_wdata;
   logic                   r_bus_err;
   logic [c_reg_bus_w-1:0] r_inst_rdata;
   logic [c_reg_bus_w-1:0] r_data_rdata;

   logic                   w_stall_mem;
   logic                   w_stall_if;
   logic                   w_advance;
   logic                   w_in_bus;
   logic                   w_expired;
   logic                   w_done;
   logic                   w_err;
   logic                   w_keep;        // completion result is delivered
   logic                   w_start;
   logic [c_reg_bus_w-1:0] w_rd;

   assign w_stall_mem = bif.data_ce_i & ~r_served_d;
   assign w_stall_if  = bif.inst_ce_i & ~r_served_i;
   assign w_advance   = ~w_stall_mem & ~w_stall_if;

   assign w_in_bus = (r_state != ARB_IDLE);
   // Ack on the last allowed cycle wins over the timeout
   assign w_done   = w_in_bus & (bif.bus_ack_i | w_expired);
   assign w_err    = w_in_bus & w_expired & ~bif.bus_ack_i;
   assign w_rd     = bif.bus_ack_i ? bif.bus_rdata_i : '0;
   assign w_keep   = w_done & ~bif.flush_i & ~r_flushed;

   bus_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_start),
      .i_en      (w_in_bus),
      .o_expired (w_expired)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (!bif.flush_i) begin
               if (w_stall_mem) begin
                  w_state_nxt = ARB_BUS_DATA;
                  w_start     = 1'b1;
               end else if (w_stall_if) begin
                  w_state_nxt = ARB_BUS_INST;
                  w_start     = 1'b1;
               end
            end
         end
         ARB_BUS_DATA, ARB_BUS_INST: begin
            if (w_done) begin
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // ---------------- bus fields, results, served flags ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_served_d   <= 1'b0;
         r_served_i   <= 1'b0;
         r_flushed    <= 1'b0;
         r_bus_req    <= 1'b0;
         r_bus_we     <= 1'b0;
         r_bus_sel    <= '0;
         r_bus_addr   <= '0;
         r_bus_wdata  <= '0;
         r_bus_err    <= 1'b0;
         r_inst_rdata <= '0;
         r_data_rdata <= '0;
      end else begin
         r_bus_err <= w_err;

         if (w_start) begin
            r_bus_req <= 1'b1;
            r_flushed <= 1'b0;
            if (w_state_nxt == ARB_BUS_DATA) begin
               r_bus_we    <= bif.data_we_i;
               r_bus_sel   <= bif.data_sel_i;
               r_bus_addr  <= bif.data_addr_i;
               r_bus_wdata <= bif.data_wdata_i;
            end else begin
               r_bus_we    <= 1'b0;
               r_bus_sel   <= c_sel_all;
               r_bus_addr  <= bif.inst_addr_i;
               r_bus_wdata <= '0;
            end
         end else if (w_done) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
         end

         // A flush anywhere in the bus cycle makes its result stale
         if (w_in_bus && bif.flush_i) begin
            r_flushed <= 1'b1;
         end

         if (w_keep) begin
            if (owner_of(r_state) == c_req_data) begin
               r_served_d <= 1'b1;
               if (!r_bus_we) begin
                  r_data_rdata <= w_rd;
               end
            end else begin
               r_served_i   <= 1'b1;
               r_inst_rdata <= w_rd;
            end
         end

         // Completion only happens while its owner stalls, so this never
         // races with a served-flag set above.
         if (w_advance || bif.flush_i) begin
            r_served_d <= 1'b0;
            r_served_i <= 1'b0;
         end
      end
   end

   assign bif.stallreq_mem_o = w_stall_mem;
   assign bif.stallreq_if_o  = w_stall_if;
   assign bif.bus_req_o      = r_bus_req;
   assign bif.bus_we_o       = r_bus_we;
   assign bif.bus_sel_o      = r_bus_sel;
   assign bif.bus_addr_o     = r_bus_addr;
   assign bif.bus_wdata_o    = r_bus_wdata;
   assign bif.bus_err_o      = r_bus_err;
   assign bif.inst_rdata_o   = r_inst_rdata;
   assign bif.data_rdata_o   = r_data_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Directed self-checking bench for mem_bus_arbiter. Inputs are
//                driven at the falling edge, outputs checked 1 time unit later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_bus_arbiter_if bif();

   mem_bus_arbiter #(
      .TIMEOUT (TIMEOUT)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bif (bif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"},   {31'd0, bif.bus_req_o},  32'd0);
      check({tag, "_we"},    {31'd0, bif.bus_we_o},   32'd0);
      check({tag, "_sel"},   {28'd0, bif.bus_sel_o},  32'd0);
      check({tag, "_addr"},  bif.bus_addr_o,          32'd0);
      check({tag, "_wdata"}, bif.bus_wdata_o,         32'd0);
      check({tag, "_err"},   {31'd0, bif.bus_err_o},  32'd0);
      check({tag, "_irdat"}, bif.inst_rdata_o,        32'd0);
      check({tag, "_drdat"}, bif.data_rdata_o,        32'd0);
      check({tag, "_stif"},  {31'd0, bif.stallreq_if_o},  32'd0);
      check({tag, "_stmem"}, {31'd0, bif.stallreq_mem_o}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      rst              = 1'b1;
      bif.flush_i      = 1'b0;
      bif.inst_ce_i    = 1'b0;
      bif.inst_addr_i  = '0;
      bif.data_ce_i    = 1'b0;
      bif.data_we_i    = 1'b0;
      bif.data_sel_i   = '0;
      bif.data_addr_i  = '0;
      bif.data_wdata_i = '0;
      bif.bus_rdata_i  = '0;
      bif.bus_ack_i    = 1'b0;
      repeat (3) cyc();
      #1 check_all_zero("reset");
      rst = 1'b0;
      cyc();

      // ---- fetch only, W=0 ----
      bif.inst_ce_i = 1'b1; bif.inst_addr_i = 32'h0000_0040;
      #1 check("t1_stall_req", {31'd0, bif.stallreq_if_o}, 32'd1);
      check("t1_req_n", {31'd0, bif.bus_req_o}, 32'd0);
      cyc(); #1
      check("t1_req", {31'd0, bif.bus_req_o}, 32'd1);
      check("t1_addr", bif.bus_addr_o, 32'h40);
      check("t1_sel", {28'd0, bif.bus_sel_o}, 32'hF);
      check("t1_we", {31'd0, bif.bus_we_o}, 32'd0);
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'h2402_0005;
      cyc(); bif.bus_ack_i = 1'b0; bif.bus_rdata_i = '0; #1
      check("t1_req_drop", {31'd0, bif.bus_req_o}, 32'd0);
      check("t1_irdat", bif.inst_rdata_o, 32'h2402_0005);
      check("t1_stall_rel", {31'd0, bif.stallreq_if_o}, 32'd0);
      bif.inst_ce_i = 1'b0;
      cyc(); #1
      check("t1_noreissue", {31'd0, bif.bus_req_o}, 32'd0);

      // ---- data load + fetch together, data first ----
      bif.data_ce_i = 1'b1; bif.data_we_i = 1'b0; bif.data_sel_i = 4'b0100;
      bif.data_addr_i = 32'h100; bif.inst_ce_i = 1'b1; bif.inst_addr_i = 32'h44;
      #1 check("t2_stmem", {31'd0, bif.stallreq_mem_o}, 32'd1);
      cyc(); #1
      check("t2_d_addr", bif.bus_addr_o, 32'h100);
      check("t2_d_sel", {28'd0, bif.bus_sel_o}, 32'h4);
      check("t2_d_we", {31'd0, bif.bus_we_o}, 32'd0);
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'h1122_3344;
      cyc(); bif.bus_ack_i = 1'b0; #1
      check("t2_gap", {31'd0, bif.bus_req_o}, 32'd0);
      check("t2_drdat", bif.data_rdata_o, 32'h1122_3344);
      check("t2_stmem_rel", {31'd0, bif.stallreq_mem_o}, 32'd0);
      check("t2_stif_held", {31'd0, bif.stallreq_if_o}, 32'd1);
      cyc(); #1
      check("t2_i_req", {31'd0, bif.bus_req_o}, 32'd1);
      check("t2_i_addr", bif.bus_addr_o, 32'h44);
      check("t2_i_sel", {28'd0, bif.bus_sel_o}, 32'hF);
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'h8C82_0000;
      cyc(); bif.bus_ack_i = 1'b0; #1
      check("t2_irdat", bif.inst_rdata_o, 32'h8C82_0000);
      check("t2_both_rel", {30'd0, bif.stallreq_if_o, bif.stallreq_mem_o}, 32'd0);
      check("t2_drdat_hold", bif.data_rdata_o, 32'h1122_3344);
      bif.data_ce_i = 1'b0; bif.inst_ce_i = 1'b0;
      cyc(); #1
      check("t2_noreissue", {31'd0, bif.bus_req_o}, 32'd0);

      // ---- store word, W=3 ----
      bif.data_ce_i = 1'b1; bif.data_we_i = 1'b1; bif.data_sel_i = 4'b1111;
      bif.data_addr_i = 32'h200; bif.data_wdata_i = 32'hDEAD_BEEF;
      for (int k = 1; k <= 4; k++) begin
         cyc(); #1
         check($sformatf("t3_req_c%0d", k), {31'd0, bif.bus_req_o}, 32'd1);
         check($sformatf("t3_fields_c%0d", k),
               {27'd0, bif.bus_we_o, bif.bus_sel_o}, 32'h1F);
         check($sformatf("t3_wdata_c%0d", k), bif.bus_wdata_o, 32'hDEAD_BEEF);
         check($sformatf("t3_addr_c%0d", k), bif.bus_addr_o, 32'h200);
         if (k == 4) begin
            bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'hFFFF_FFFF;
         end
      end
      cyc(); bif.bus_ack_i = 1'b0; bif.bus_rdata_i = '0; #1
      check("t3_req_drop", {31'd0, bif.bus_req_o}, 32'd0);
      check("t3_drdat_keep", bif.data_rdata_o, 32'h1122_3344);
      check("t3_stmem_rel", {31'd0, bif.stallreq_mem_o}, 32'd0);
      bif.data_ce_i = 1'b0; bif.data_we_i = 1'b0; bif.data_wdata_i = '0;
      cyc();

      // ---- timeout: no ack ----
      bif.inst_ce_i = 1'b1; bif.inst_addr_i = 32'h80;
      for (int k = 1; k <= TIMEOUT; k++) begin
         cyc(); #1
         check($sformatf("t4_req_c%0d", k), {30'd0, bif.bus_req_o, bif.bus_err_o}, 32'd2);
      end
      cyc(); #1
      check("t4_err", {31'd0, bif.bus_err_o}, 32'd1);
      check("t4_req_drop", {31'd0, bif.bus_req_o}, 32'd0);
      check("t4_irdat0", bif.inst_rdata_o, 32'd0);
      check("t4_stall_rel", {31'd0, bif.stallreq_if_o}, 32'd0);
      bif.inst_ce_i = 1'b0;
      cyc(); #1
      check("t4_err_pulse", {31'd0, bif.bus_err_o}, 32'd0);

      // ---- ack on the timeout cycle wins ----
      bif.inst_ce_i = 1'b1; bif.inst_addr_i = 32'h84;
      repeat (TIMEOUT - 1) cyc();
      cyc(); #1
      check("t4b_req_last", {31'd0, bif.bus_req_o}, 32'd1);
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'hA5A5_0001;
      cyc(); bif.bus_ack_i = 1'b0; bif.bus_rdata_i = '0; #1
      check("t4b_no_err", {31'd0, bif.bus_err_o}, 32'd0);
      check("t4b_irdat", bif.inst_rdata_o, 32'hA5A5_0001);
      check("t4b_stall_rel", {31'd0, bif.stallreq_if_o}, 32'd0);
      bif.inst_ce_i = 1'b0;
      cyc();

      // ---- flush during fetch, W=2 ----
      bif.inst_ce_i = 1'b1; bif.inst_addr_i = 32'h90;
      cyc(); #1
      check("t5_addr", bif.bus_addr_o, 32'h90);
      bif.flush_i = 1'b1; bif.inst_addr_i = 32'hA0;
      cyc(); bif.flush_i = 1'b0; #1
      check("t5_req_cont", {31'd0, bif.bus_req_o}, 32'd1);
      check("t5_addr_held", bif.bus_addr_o, 32'h90);
      cyc(); #1
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'h0BAD_F00D;
      cyc(); bif.bus_ack_i = 1'b0; bif.bus_rdata_i = '0; #1
      check("t5_req_drop", {31'd0, bif.bus_req_o}, 32'd0);
      check("t5_irdat_keep", bif.inst_rdata_o, 32'hA5A5_0001);
      check("t5_stall_held", {31'd0, bif.stallreq_if_o}, 32'd1);
      cyc(); #1
      check("t5_new_addr", bif.bus_addr_o, 32'hA0);
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'h0000_0AA0;
      cyc(); bif.bus_ack_i = 1'b0; bif.bus_rdata_i = '0; #1
      check("t5_new_irdat", bif.inst_rdata_o, 32'h0000_0AA0);
      check("t5_stall_rel", {31'd0, bif.stallreq_if_o}, 32'd0);
      bif.inst_ce_i = 1'b0;
      cyc();

      // ---- reset mid-transaction ----
      bif.inst_ce_i = 1'b1; bif.inst_addr_i = 32'hB0;
      cyc(); #1
      check("t6_req", {31'd0, bif.bus_req_o}, 32'd1);
      rst = 1'b1; bif.inst_ce_i = 1'b0;
      cyc(); #1
      check_all_zero("t6_rst");
      rst = 1'b0; bif.inst_ce_i = 1'b1; bif.inst_addr_i = 32'hC0;
      cyc(); #1
      check("t6_restart_addr", bif.bus_addr_o, 32'hC0);
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'h77;
      cyc(); bif.bus_ack_i = 1'b0; #1
      check("t6_irdat", bif.inst_rdata_o, 32'h77);
      bif.inst_ce_i = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
